// File: rtl/mult_ctrl.sv
// Sequencing controller for a multi-cycle multiplier: accepts one request at a time,
// steps the datapath through sign fix-up, partial products, reduction and latch, then holds the result.
module mult_ctrl #(
    parameter int unsigned REDUCE_CYCLES = 1,
    parameter int unsigned OP_W          = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [OP_W-1:0] mult_op,
    input  logic            rs1_msb,
    input  logic            rs2_msb,
    input  logic            flush,
    output logic            start,
    output logic            compute_sign,
    output logic            flip_rs1,
    output logic            flip_rs2,
    output logic            i_rdy,
    output logic            mult_done,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic            o_rdy,
    output logic            sel_high,
    output logic [OP_W-1:0] op_q,
    output logic            busy
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SIGN   = 3'd1,
        ST_PP     = 3'd2,
        ST_REDUCE = 3'd3,
        ST_LATCH  = 3'd4,
        ST_RESP   = 3'd5
    } state_t;

    typedef struct packed {
        logic req_ready;
        logic compute_sign;
        logic flip_rs1;
        logic flip_rs2;
        logic i_rdy;
        logic mult_done;
        logic resp_valid;
        logic sel_high;
        logic busy;
    } strobes_t;

    localparam logic [OP_W-1:0] OP_MUL    = OP_W'(2'd0);
    localparam logic [OP_W-1:0] OP_MULH   = OP_W'(2'd1);
    localparam logic [OP_W-1:0] OP_MULHSU = OP_W'(2'd2);
    localparam logic [2:0]      RC        = 3'(REDUCE_CYCLES);
    localparam strobes_t        OUT_IDLE  = '{req_ready: 1'b1, default: 1'b0};

    // Operand negation needed before an unsigned array multiply, per opcode signedness.
    function automatic logic [1:0] flip_flags(input logic [OP_W-1:0] op, input logic m1, input logic m2);
        logic [1:0] f;
        case (op)
            OP_MUL, OP_MULH: f = {m1, m2};
            OP_MULHSU:       f = {m1, 1'b0};
            default:         f = 2'b00;
        endcase
        return f;
    endfunction

    // Strobe pattern presented while the controller sits in a given state.
    function automatic strobes_t out_for(input state_t st, input logic f1, input logic f2, input logic hi);
        strobes_t o;
        o = '0;
        case (st)
            ST_IDLE:   o.req_ready = 1'b1;
            ST_SIGN:   begin
                o.compute_sign = 1'b1;
                o.flip_rs1     = f1;
                o.flip_rs2     = f2;
            end
            ST_PP:     o.i_rdy = 1'b1;
            ST_REDUCE: o.i_rdy = 1'b0;
            ST_LATCH:  o.mult_done = 1'b1;
            ST_RESP:   begin
                o.resp_valid = 1'b1;
                o.sel_high   = hi;
            end
            default:   o.req_ready = 1'b1;
        endcase
        o.busy = ~o.req_ready;
        return o;
    endfunction

    state_t          r_state;
    strobes_t        r_out;
    logic [2:0]      r_cnt;
    logic [OP_W-1:0] r_op;
    logic [1:0]      r_flip;
    logic [1:0]      w_flags;

    assign w_flags = flip_flags(mult_op, rs1_msb, rs2_msb);

    // Controller FSM; strobes are loaded together with the state they belong to.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_out   <= OUT_IDLE;
            r_cnt   <= 3'd0;
            r_op    <= '0;
            r_flip  <= 2'b00;
        end else if (flush) begin
            r_state <= ST_IDLE;
            r_out   <= OUT_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        r_state <= ST_SIGN;
                        r_op    <= mult_op;
                        r_flip  <= w_flags;
                        r_out   <= out_for(ST_SIGN, w_flags[1], w_flags[0], 1'b0);
                    end else begin
                        r_out   <= OUT_IDLE;
                    end
                end
                ST_SIGN: begin
                    r_state <= ST_PP;
                    r_out   <= out_for(ST_PP, 1'b0, 1'b0, 1'b0);
                end
                ST_PP: begin
                    r_cnt <= RC;
                    if (RC != 3'd0) begin
                        r_state <= ST_REDUCE;
                        r_out   <= out_for(ST_REDUCE, 1'b0, 1'b0, 1'b0);
                    end else begin
                        r_state <= ST_LATCH;
                        r_out   <= out_for(ST_LATCH, 1'b0, 1'b0, 1'b0);
                    end
                end
                ST_REDUCE: begin
                    r_cnt <= r_cnt - 3'd1;
                    // <= 1 rather than == 1 so a corrupted zero count cannot trap the FSM here.
                    if (r_cnt <= 3'd1) begin
                        r_state <= ST_LATCH;
                        r_out   <= out_for(ST_LATCH, 1'b0, 1'b0, 1'b0);
                    end
                end
                ST_LATCH: begin
                    r_state <= ST_RESP;
                    r_out   <= out_for(ST_RESP, 1'b0, 1'b0, r_op != OP_MUL);
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        r_state <= ST_IDLE;
                        r_out   <= OUT_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_out   <= OUT_IDLE;
                end
            endcase
        end
    end

    assign req_ready    = r_out.req_ready;
    assign start        = req_valid & r_out.req_ready & ~flush;
    assign compute_sign = r_out.compute_sign;
    assign flip_rs1     = r_out.flip_rs1;
    assign flip_rs2     = r_out.flip_rs2;
    assign i_rdy        = r_out.i_rdy;
    assign mult_done    = r_out.mult_done;
    assign resp_valid   = r_out.resp_valid;
    assign o_rdy        = r_out.resp_valid;
    assign sel_high     = r_out.sel_high;
    assign busy         = r_out.busy;
    assign op_q         = r_op;

endmodule
